// File: rtl/latent_noise_pkg.sv
`default_nettype none
// ============================================================================
// latent_noise_pkg : shared constants, FSM state type and LFSR helpers
// Rev 1.0
// ============================================================================
package latent_noise_pkg;

   localparam int LFSR_W = 16;
   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
   // Feedback taps at bits 15, 13, 12 and 10
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_CAPTURE = 2'd2
   } state_e;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
      return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
   endfunction

   function automatic logic [LFSR_W-1:0] rotl16(input logic [LFSR_W-1:0] v,
                                                input logic [3:0] r);
      logic [2*LFSR_W-1:0] t;
      t = {v, v} << r;
      return t[2*LFSR_W-1:LFSR_W];
   endfunction

   function automatic logic [LFSR_W-1:0] q88_scale(input logic [LFSR_W-1:0] l);
      return {{7{l[LFSR_W-1]}}, l[LFSR_W-1:7]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16_lane.sv
`default_nettype none
// ============================================================================
// lfsr16_lane : one seedable 16-bit Fibonacci LFSR lane with Q8.8 output
// Rev 1.0
// ============================================================================
module lfsr16_lane
   import latent_noise_pkg::*;
#(
   parameter int LANE_IDX = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              step_i,
   input  logic              mode_i,
   input  logic [LFSR_W-1:0] seed_i,
   output logic [LFSR_W-1:0] sample_o
);

   localparam logic [3:0] ROT = 4'((2 * LANE_IDX) % 16);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = rotl16(seed_i, ROT);
      end else if (step_i) begin
         lfsr_d = lfsr_next(lfsr_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= rotl16(DEFAULT_SEED, ROT);
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   // The sample is the pre-step state; the caller registers it
   assign sample_o = mode_i ? q88_scale(lfsr_q) : lfsr_q;

endmodule
`default_nettype wire

// File: rtl/latent_noise_gen.sv
`default_nettype none
// ============================================================================
// latent_noise_gen : multi-lane LFSR latent vector filler with sample stream
// Rev 1.0
// ============================================================================
module latent_noise_gen
   import latent_noise_pkg::*;
#(
   parameter int SEED_COUNT = 64,
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             reseed,
   input  logic [LFSR_W-1:0]                seed,
   input  logic                             mode,
   output logic [DATA_WIDTH*SEED_COUNT-1:0] seed_flat,
   output logic [LANES*DATA_WIDTH-1:0]      sample_data,
   output logic                             sample_valid,
   output logic                             busy,
   output logic                             done
);

   localparam int N     = SEED_COUNT / LANES;
   localparam int CNT_W = $clog2(N) + 1;
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(N);

   state_e                          state_q;
   logic [CNT_W-1:0]                cnt_q;
   logic                            mode_q;
   logic                            reseed_q;
   logic [LFSR_W-1:0]               seed_q;
   logic                            busy_q;
   logic                            done_q;
   logic                            valid_q;
   logic [LANES*DATA_WIDTH-1:0]     sample_data_q;
   logic [DATA_WIDTH*SEED_COUNT-1:0] seed_flat_q;
   logic [DATA_WIDTH*SEED_COUNT-1:0] seed_flat_d;

   logic [LANES*DATA_WIDTH-1:0]     lane_samples;
   logic                            capture_en;
   logic                            lane_load;

   assign capture_en = (state_q == ST_CAPTURE) && (cnt_q < CNT_END);
   assign lane_load  = (state_q == ST_LOAD) && reseed_q;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      lfsr16_lane #(
         .LANE_IDX(k)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .load_i   (lane_load),
         .step_i   (capture_en),
         .mode_i   (mode_q),
         .seed_i   (seed_q),
         .sample_o (lane_samples[k*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   // The count reaching N is a one-cycle drain so done lands N+2 cycles after start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         mode_q        <= 1'b0;
         reseed_q      <= 1'b0;
         seed_q        <= DEFAULT_SEED;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         valid_q       <= 1'b0;
         sample_data_q <= '0;
      end else begin
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q  <= ST_LOAD;
                  busy_q   <= 1'b1;
                  mode_q   <= mode;
                  reseed_q <= reseed;
                  if (reseed) begin
                     seed_q <= (seed == '0) ? DEFAULT_SEED : seed;
                  end
               end
            end
            ST_LOAD: begin
               state_q <= ST_CAPTURE;
               cnt_q   <= '0;
            end
            ST_CAPTURE: begin
               if (capture_en) begin
                  cnt_q         <= cnt_q + 1'b1;
                  valid_q       <= 1'b1;
                  sample_data_q <= lane_samples;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      seed_flat_d = seed_flat_q;
      for (int i = 0; i < SEED_COUNT; i++) begin
         if (capture_en && (cnt_q == CNT_W'(i / LANES))) begin
            seed_flat_d[i*DATA_WIDTH +: DATA_WIDTH] =
               lane_samples[(i % LANES)*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seed_flat_q <= '0;
      end else begin
         seed_flat_q <= seed_flat_d;
      end
   end

   assign seed_flat    = seed_flat_q;
   assign sample_data  = sample_data_q;
   assign sample_valid = valid_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_latent_noise_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_latent_noise_gen : directed, table-driven self-checking bench
// Rev 1.0
// ============================================================================
module tb_latent_noise_gen;

   localparam int SC = 64;
   localparam int LN = 4;
   localparam int NC = SC / LN;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            reseed = 1'b0;
   logic            mode = 1'b0;
   logic [15:0]     seed = 16'h0;
   logic [16*SC-1:0] seed_flat;
   logic [16*LN-1:0] sample_data;
   logic            sample_valid;
   logic            busy;
   logic            done;

   latent_noise_gen #(
      .SEED_COUNT(SC),
      .DATA_WIDTH(16),
      .LANES(LN)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .reseed       (reseed),
      .seed         (seed),
      .mode         (mode),
      .seed_flat    (seed_flat),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          r;
      logic [15:0] s;
      bit          m;
      logic [15:0] e0;
      logic [15:0] e1;
   } vec_t;

   int n_chk  = 0;
   int n_pass = 0;

   logic [15:0]      mlane [LN];
   logic [15:0]      exp_vec [SC];
   bit               cur_mode;
   logic [16*SC-1:0] vec_ref;
   logic [16*SC-1:0] vec_run1;
   int               lat;
   int               cap;
   bit               stream_ok;
   bit               got_done;
   bit               aborted;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [15:0] m_step(input logic [15:0] v);
      logic fb;
      fb = v[15] ^ v[13] ^ v[12] ^ v[10];
      return {v[14:0], fb};
   endfunction

   function automatic logic [15:0] m_rotl(input logic [15:0] v, input int n);
      if (n == 0) return v;
      return (v << n) | (v >> (16 - n));
   endfunction

   function automatic logic [15:0] m_q88(input logic [15:0] v);
      logic signed [15:0] t;
      t = v;
      return t >>> 7;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < LN; k++) mlane[k] = m_rotl(16'hACE1, 2 * k);
   endtask

   // Drive a start request and advance the reference lanes through one full vector
   task automatic launch(input bit r, input logic [15:0] s, input bit m);
      logic [15:0] base;
      start = 1'b1; reseed = r; seed = s; mode = m; cur_mode = m;
      base = (s == 16'h0) ? 16'hACE1 : s;
      if (r) for (int k = 0; k < LN; k++) mlane[k] = m_rotl(base, 2 * k);
      for (int j = 0; j < NC; j++) begin
         for (int k = 0; k < LN; k++) begin
            exp_vec[j*LN+k] = m ? m_q88(mlane[k]) : mlane[k];
            mlane[k] = m_step(mlane[k]);
         end
      end
   endtask

   task automatic collect(input string tag, input bit inject, input bit b2b, input int abort_cap);
      int bad;
      @(posedge clk); #1;
      start = 1'b0; reseed = 1'b0; seed = 16'hDEAD; mode = ~cur_mode;
      lat = 0; cap = 0; stream_ok = 1'b1; got_done = 1'b0; aborted = 1'b0;
      while (!got_done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) chk({tag, "_busy"}, busy, 1);
         if (inject && lat == 5) begin start = 1'b1; reseed = 1'b1; seed = 16'h1234; mode = ~mode; end
         if (inject && lat == 6) start = 1'b0;
         if (sample_valid) begin
            if (cap < NC) begin
               for (int k = 0; k < LN; k++)
                  if (sample_data[k*16 +: 16] !== exp_vec[cap*LN+k]) stream_ok = 1'b0;
            end
            cap++;
            if (cap == abort_cap) begin
               rst_n = 1'b0; #1;
               chk({tag, "_abort_zero"}, {|seed_flat, |sample_data, sample_valid, busy, done}, 0);
               aborted = 1'b1;
               return;
            end
         end
         if (done) got_done = 1'b1;
      end
      chk({tag, "_latency"}, got_done ? lat : 999, 18);
      chk({tag, "_captures"}, cap, NC);
      chk({tag, "_stream"}, stream_ok, 1);
      bad = 0;
      for (int i = 0; i < SC; i++) if (seed_flat[i*16 +: 16] !== exp_vec[i]) bad++;
      chk({tag, "_entries_bad"}, bad, 0);
      if (got_done && !b2b) begin
         @(posedge clk); #1;
         chk({tag, "_done_pulse"}, {done, busy}, 0);
      end
   endtask

   initial begin
      vec_t        tbl [5];
      logic [15:0] v;
      int          cnt;

      tbl[0] = '{r: 1'b1, s: 16'hACE1, m: 1'b0, e0: 16'hACE1, e1: 16'hB386};
      tbl[1] = '{r: 1'b1, s: 16'hACE1, m: 1'b1, e0: 16'hFF59, e1: 16'hFF67};
      tbl[2] = '{r: 1'b1, s: 16'h0000, m: 1'b0, e0: 16'hACE1, e1: 16'hB386};
      tbl[3] = '{r: 1'b1, s: 16'h1234, m: 1'b0, e0: 16'h1234, e1: 16'h48D0};
      tbl[4] = '{r: 1'b1, s: 16'h8001, m: 1'b1, e0: 16'hFF00, e1: 16'h0000};

      #12;
      chk("reset_zero", {|seed_flat, |sample_data, sample_valid, busy, done}, 0);
      @(negedge clk); rst_n = 1'b1;
      model_reset();

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         launch(tbl[i].r, tbl[i].s, tbl[i].m);
         collect($sformatf("vec%0d", i), 1'b0, 1'b0, -1);
         chk($sformatf("vec%0d_e0", i), seed_flat[15:0], tbl[i].e0);
         chk($sformatf("vec%0d_e1", i), seed_flat[31:16], tbl[i].e1);
         if (i == 0) vec_ref = seed_flat;
         if (tbl[i].m) begin
            cnt = 0;
            for (int e = 0; e < SC; e++) begin
               v = seed_flat[e*16 +: 16];
               if (!(v >= 16'hFF00 || v <= 16'h00FF)) cnt++;
            end
            chk($sformatf("vec%0d_range_bad", i), cnt, 0);
         end
         if (i == 2) begin
            chk("zero_seed_same", seed_flat == vec_ref, 1);
            cnt = 0;
            for (int e = 0; e < SC; e++) if (seed_flat[e*16 +: 16] == 16'h0) cnt++;
            chk("zero_seed_zero_entries", cnt, 0);
         end
      end

      // Continuation after reset: behaves as 0xACE1 seeded, then continues
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      launch(1'b0, 16'h5555, 1'b0);
      collect("cont1", 1'b0, 1'b0, -1);
      chk("cont1_as_ace1", seed_flat == vec_ref, 1);
      vec_run1 = seed_flat;
      @(negedge clk);
      launch(1'b0, 16'h7777, 1'b0);
      collect("cont2", 1'b0, 1'b0, -1);
      chk("cont2_differs", seed_flat != vec_run1, 1);
      v = 16'hACE1;
      for (int s = 0; s < NC; s++) v = m_step(v);
      chk("cont2_e0", seed_flat[15:0], v);

      // Start while busy is ignored
      @(negedge clk);
      launch(1'b1, 16'h4321, 1'b0);
      collect("busy_start", 1'b1, 1'b0, -1);
      chk("busy_start_e0", seed_flat[15:0], 16'h4321);

      // Back-to-back: start asserted in the done cycle
      @(negedge clk);
      launch(1'b1, 16'hBEEF, 1'b1);
      collect("b2b_a", 1'b0, 1'b1, -1);
      chk("b2b_a_e0", seed_flat[15:0], 16'hFF7D);
      launch(1'b1, 16'h0001, 1'b0);
      collect("b2b_b", 1'b0, 1'b0, -1);
      chk("b2b_b_e0", seed_flat[15:0], 16'h0001);

      // Reset at capture 5, then a fresh run matches the first scenario
      @(negedge clk);
      launch(1'b1, 16'hACE1, 1'b0);
      collect("abort", 1'b0, 1'b0, 5);
      chk("abort_taken", aborted, 1);
      @(negedge clk); rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      launch(1'b1, 16'hACE1, 1'b0);
      collect("post_reset", 1'b0, 1'b0, -1);
      chk("post_reset_same", seed_flat == vec_ref, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
